led_pattern_ctrl: RTL
=====================

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 Parameter: DIV, default 50_000_000, number of board_clk cycles per pattern step (minimum 2).
REQ-002 Parameter: DB_CYCLES, default 1_000_000, number of cycles the synchronized button must differ continuously before it is accepted (minimum 2).
REQ-003 Port: board_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: switch  input  1  run enable; 1 = patterns advance, 0 = freeze.
REQ-006 Port: btn  input  1  asynchronous push-button; each accepted press advances the mode.
REQ-007 Port: led  output  4  registered LED drive.
REQ-008 Port: mode  output  2  registered current mode: 0 OFF, 1 BLINK, 2 CHASE, 3 COUNT.

Function
REQ-009 btn SHALL pass through a 2-flop synchronizer; btn_s is the second-flop output.
REQ-010 Debounce: db_cnt SHALL clear whenever btn_s equals btn_stable and SHALL increment while they differ.
REQ-011 When btn_s differs from btn_stable and db_cnt equals DB_CYCLES-1, the block SHALL load btn_stable from btn_s and clear db_cnt.
REQ-012 A press pulse SHALL assert for exactly one cycle on each 0->1 transition of btn_stable; 1->0 transitions SHALL NOT generate a pulse.
REQ-013 Mode FSM transitions on press: OFF->BLINK->CHASE->COUNT->OFF; with no press, mode SHALL hold.
REQ-014 Press SHALL be honoured regardless of switch.
REQ-015 Prescaler, switch=1: presc SHALL count 0..DIV-1, wrap to 0, and assert a one-cycle tick on the cycle presc==DIV-1.
REQ-016 Prescaler, switch=0: presc SHALL hold its value and tick SHALL be 0.
REQ-017 On the edge where press is sampled, mode SHALL advance, presc SHALL clear to 0, and led SHALL load the new mode's entry pattern in that same edge.
REQ-018 Entry patterns: OFF 0000, BLINK 1111, CHASE 0001, COUNT 0000.
REQ-019 Press and tick coinciding: press SHALL take priority and the tick SHALL be discarded (led = entry pattern, not stepped).
REQ-020 On tick with no press, led SHALL step per mode:
- OFF: stays 0000
- BLINK: bitwise invert
- CHASE: rotate left (1000->0001)
- COUNT: +1 modulo 16 (1111->0000)
REQ-021 Without tick or press, led SHALL hold; switch=0 therefore freezes led at its current value, and the pattern resumes from that value when switch returns to 1.
REQ-022 All arithmetic SHALL be unsigned; presc and db_cnt SHALL be sized to hold DIV-1 and DB_CYCLES-1 respectively.

Reset
REQ-023 While reset=1, the block SHALL immediately force led=0000, mode=OFF, presc=0, db_cnt=0, btn_stable=0, synchronizer flops=0 and press=0, independent of board_clk.
REQ-024 Reset asserted mid-pattern or mid-debounce SHALL discard all progress; a button held through reset release SHALL be accepted as a new press after DB_CYCLES cycles of btn_s=1.
REQ-025 After reset release the block SHALL resume on the first rising edge, with presc counting from 0 if switch=1.

Verification (DIV=4, DB_CYCLES=3)
REQ-026 Reset, switch=1, no press, 20 cycles -> led=0000, mode=0 throughout.
REQ-027 btn held 1 -> exactly one press and mode=1/led=1111 at the fixed latency of 2 sync + 3 debounce + 1 edge-detect + 1 update cycles; then led toggles 0000/1111 every 4 cycles; releasing btn produces no mode change.
REQ-028 btn bounce (1 for 2 cycles, 0 for 1 cycle, repeated) -> no mode change; then held 1 -> a single advance.
REQ-029 Four clean presses -> mode sequence 1,2,3,0. In CHASE led = 0001,0010,0100,1000,0001 every 4 cycles. In COUNT led counts 0000..1111 then wraps to 0000.
REQ-030 Press timed to land on the tick cycle -> led shows the entry pattern and presc restarts at 0, with the next step 4 cycles later. Separately, switch=0 mid-COUNT at led=0101 for 10 cycles -> led stays 0101, then steps to 0110 4 cycles after switch returns to 1 (presc held).
REQ-031 reset pulsed while in CHASE with led=0100 and db_cnt nonzero -> led=0000 and mode=0 asynchronously, before the next clock edge, with no spurious press after release.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: button-driven LED pattern generator.
//   board_clk : single clock, rising edge
//   reset     : asynchronous, active-high reset
//   switch    : run enable (1 = patterns advance, 0 = freeze)
//   btn       : asynchronous push-button; each debounced press advances mode
//   led[3:0]  : registered LED drive
//   mode[1:0] : registered mode (0 OFF, 1 BLINK, 2 CHASE, 3 COUNT)
module led_pattern_ctrl #(
    parameter int unsigned DIV       = 50_000_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       switch,
    input  logic       btn,
    output logic [3:0] led,
    output logic [1:0] mode
);

    localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned DW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_BLINK = 2'd1;
    localparam logic [1:0] S_CHASE = 2'd2;
    localparam logic [1:0] S_COUNT = 2'd3;

    logic          sync1;
    logic          btn_s;
    logic          btn_stable;
    logic          stable_q;
    logic          press;
    logic [DW-1:0] db_cnt;
    logic [PW-1:0] presc;

    logic          tick_c;
    logic [1:0]    mode_nxt;
    logic [3:0]    led_nxt;
    logic [PW-1:0] presc_nxt;

    // Synchronizer, debounce counter and rising-edge press detector
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            btn_s      <= 1'b0;
            btn_stable <= 1'b0;
            stable_q   <= 1'b0;
            press      <= 1'b0;
            db_cnt     <= '0;
        end else begin
            sync1    <= btn;
            btn_s    <= sync1;
            stable_q <= btn_stable;
            press    <= btn_stable & ~stable_q;
            if (btn_s == btn_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_stable <= btn_s;
                db_cnt     <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    assign tick_c = switch && (presc == PRESC_LAST);

    // Mode FSM, LED pattern and prescaler state register
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            mode  <= S_OFF;
            led   <= 4'b0000;
            presc <= '0;
        end else begin
            mode  <= mode_nxt;
            led   <= led_nxt;
            presc <= presc_nxt;
        end
    end

    // Next state: a press wins over a coincident tick and restarts the step timer
    always_comb begin
        mode_nxt  = mode;
        led_nxt   = led;
        presc_nxt = presc;
        if (press) begin
            presc_nxt = '0;
            case (mode)
                S_OFF:   mode_nxt = S_BLINK;
                S_BLINK: mode_nxt = S_CHASE;
                S_CHASE: mode_nxt = S_COUNT;
                default: mode_nxt = S_OFF;
            endcase
            case (mode_nxt)
                S_BLINK: led_nxt = 4'b1111;
                S_CHASE: led_nxt = 4'b0001;
                default: led_nxt = 4'b0000;
            endcase
        end else if (switch) begin
            presc_nxt = tick_c ? '0 : presc + PW'(1);
            if (tick_c) begin
                case (mode)
                    S_BLINK: led_nxt = ~led;
                    S_CHASE: led_nxt = {led[2:0], led[3]};
                    S_COUNT: led_nxt = led + 4'd1;
                    default: led_nxt = 4'b0000;
                endcase
            end
        end
    end

endmodule
